// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life generation store.
//   state_t  : controller states (IDLE, SCAN, DRAIN, SWAP)
//   rows_of  : number of rows for a given row-address width
//   DEF_*    : default WIDTH / REGBITS / CNTBITS values
package gol_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_REGBITS = 3;
  localparam int DEF_CNTBITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } state_t;

  function automatic int rows_of(input int regbits);
    return 1 << regbits;
  endfunction

endpackage

// File: rtl/gol_bank.sv
// One ROWS x WIDTH row store of the ping-pong pair.
//   ph2            : clock, write on rising edge
//   we/waddr/wdata : single synchronous write port
//   raddr_a/b/c    : window read ports (above, current, below)
//   raddr_d        : display read port
//   rdata_a..d     : combinational read data
module gol_bank
  import gol_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGBITS = DEF_REGBITS
) (
  input  logic               ph2,
  input  logic               we,
  input  logic [REGBITS-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [REGBITS-1:0] raddr_a,
  input  logic [REGBITS-1:0] raddr_b,
  input  logic [REGBITS-1:0] raddr_c,
  input  logic [REGBITS-1:0] raddr_d,
  output logic [WIDTH-1:0]   rdata_a,
  output logic [WIDTH-1:0]   rdata_b,
  output logic [WIDTH-1:0]   rdata_c,
  output logic [WIDTH-1:0]   rdata_d
);

  localparam int ROWS = rows_of(REGBITS);

  logic [WIDTH-1:0] mem [ROWS];

  // NOTE: the row array has no reset; its contents are meaningless until the
  // host loads them, and a reset would turn the array into individual flops.
  always_ff @(posedge ph2) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_c = mem[raddr_c];
  assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/gol_gen_buffer.sv
// Double-buffered Game-of-Life generation store.
// Scans the active bank row by row, presenting a registered above/current/
// below window over a valid/ready handshake, collects next-state rows into
// the shadow bank, then swaps banks and counts the generation.
//   ph2, reset                   : clock, async active-high reset
//   load_en/load_addr/load_data  : host row write into active bank (IDLE only)
//   start, busy                  : begin a generation / not IDLE
//   win_valid/win_ready/win_row/win_above/win_cur/win_below : window stream
//   nxt_we/nxt_addr/nxt_data     : next-state row write into shadow bank
//   gen_done, gen_count          : swap pulse, completed generation count
//   rd_addr, rd_data             : combinational readback of active bank
// Build option: define GOL_TORUS_EN for vertical toroidal wrap of the window;
// otherwise rows outside the grid read as dead (zero).
module gol_gen_buffer
  import gol_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGBITS = DEF_REGBITS,
  parameter int CNTBITS = DEF_CNTBITS
) (
  input  logic               ph2,
  input  logic               reset,
  input  logic               load_en,
  input  logic [REGBITS-1:0] load_addr,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  output logic               busy,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [REGBITS-1:0] win_row,
  output logic [WIDTH-1:0]   win_above,
  output logic [WIDTH-1:0]   win_cur,
  output logic [WIDTH-1:0]   win_below,
  input  logic               nxt_we,
  input  logic [REGBITS-1:0] nxt_addr,
  input  logic [WIDTH-1:0]   nxt_data,
  output logic               gen_done,
  output logic [CNTBITS-1:0] gen_count,
  input  logic [REGBITS-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  localparam int ROWS = rows_of(REGBITS);
  localparam logic [REGBITS-1:0] LAST = REGBITS'(ROWS - 1);

  state_t             state;
  logic               bank_sel;
  logic [REGBITS-1:0] row;
  logic [ROWS-1:0]    mask;

  logic               load_wr, nxt_wr, accept;
  logic [REGBITS-1:0] nrow, above_addr, below_addr, waddr;
  logic [WIDTH-1:0]   wdata;
  logic               we0, we1;
  logic [WIDTH-1:0]   b0_above, b0_cur, b0_below, b0_rd;
  logic [WIDTH-1:0]   b1_above, b1_cur, b1_below, b1_rd;
  logic [WIDTH-1:0]   act_above, act_cur, act_below;
  logic [WIDTH-1:0]   next_above, next_cur, next_below;
  logic [ROWS-1:0]    one_hot, mask_next;
  logic               mask_full;

  assign load_wr = (state == IDLE) && load_en;
  assign nxt_wr  = ((state == SCAN) || (state == DRAIN)) && nxt_we;
  assign accept  = (state == SCAN) && win_valid && win_ready;

  // Row whose window is loaded on the next update: row 0 on start, else row+1.
  assign nrow       = (state == IDLE) ? '0 : row + REGBITS'(1);
  assign above_addr = nrow - REGBITS'(1);
  assign below_addr = nrow + REGBITS'(1);

  // Host loads and next-state writes never share a state, so one shared
  // address/data pair serves both banks; only the enables differ.
  assign waddr = load_wr ? load_addr : nxt_addr;
  assign wdata = load_wr ? load_data : nxt_data;
  assign we0   = (load_wr && !bank_sel) || (nxt_wr && bank_sel);
  assign we1   = (load_wr && bank_sel) || (nxt_wr && !bank_sel);

  gol_bank #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_bank0 (
    .ph2(ph2), .we(we0), .waddr(waddr), .wdata(wdata),
    .raddr_a(above_addr), .raddr_b(nrow), .raddr_c(below_addr), .raddr_d(rd_addr),
    .rdata_a(b0_above), .rdata_b(b0_cur), .rdata_c(b0_below), .rdata_d(b0_rd)
  );

  gol_bank #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_bank1 (
    .ph2(ph2), .we(we1), .waddr(waddr), .wdata(wdata),
    .raddr_a(above_addr), .raddr_b(nrow), .raddr_c(below_addr), .raddr_d(rd_addr),
    .rdata_a(b1_above), .rdata_b(b1_cur), .rdata_c(b1_below), .rdata_d(b1_rd)
  );

  assign act_above = bank_sel ? b1_above : b0_above;
  assign act_cur   = bank_sel ? b1_cur   : b0_cur;
  assign act_below = bank_sel ? b1_below : b0_below;
  assign rd_data   = bank_sel ? b1_rd    : b0_rd;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_above = act_above;
    next_cur   = act_cur;
    next_below = act_below;
`ifdef GOL_TORUS_EN
    // Address arithmetic already wraps modulo ROWS; nothing to mask.
`else
    if (nrow == '0)  next_above = '0;
    if (nrow == LAST) next_below = '0;
`endif
  end

  // Mask including this cycle's write, so completion is seen without delay.
  assign one_hot   = {{(ROWS-1){1'b0}}, 1'b1} << nxt_addr;
  assign mask_next = mask | (nxt_wr ? one_hot : '0);
  assign mask_full = &mask_next;

  // NOTE: state registers use non-blocking assignments so each one samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bank_sel  <= 1'b0;
      row       <= '0;
      mask      <= '0;
      gen_count <= '0;
      gen_done  <= 1'b0;
      win_valid <= 1'b0;
      win_above <= '0;
      win_cur   <= '0;
      win_below <= '0;
    end else begin
      gen_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            row       <= '0;
            mask      <= '0;
            win_valid <= 1'b1;
            win_above <= next_above;
            win_cur   <= next_cur;
            win_below <= next_below;
          end
        end
        SCAN: begin
          mask <= mask_next;
          if (accept) begin
            if (row == LAST) begin
              win_valid <= 1'b0;
              state     <= mask_full ? SWAP : DRAIN;
            end else begin
              row       <= nrow;
              win_above <= next_above;
              win_cur   <= next_cur;
              win_below <= next_below;
            end
          end
        end
        DRAIN: begin
          mask <= mask_next;
          if (mask_full) state <= SWAP;
        end
        SWAP: begin
          bank_sel  <= ~bank_sel;
          gen_done  <= 1'b1;
          gen_count <= gen_count + CNTBITS'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign win_row = row;

endmodule

// File: tb/tb_gol_gen_buffer.sv
// Self-checking bench for gol_gen_buffer (default parameters, 8 x 8 grid).
// Expected windows and bank contents come from a row-array model of the two
// banks; window neighbours follow the dead-border or torus rule depending on
// GOL_TORUS_EN.
module tb_gol_gen_buffer;

  logic       ph2 = 1'b0;
  logic       reset = 1'b1;
  logic       load_en = 1'b0;
  logic [2:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       win_valid;
  logic       win_ready = 1'b0;
  logic [2:0] win_row;
  logic [7:0] win_above, win_cur, win_below;
  logic       nxt_we = 1'b0;
  logic [2:0] nxt_addr = '0;
  logic [7:0] nxt_data = '0;
  logic       gen_done;
  logic [15:0] gen_count;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_data;

  gol_gen_buffer dut (
    .ph2(ph2), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .busy(busy),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
    .win_above(win_above), .win_cur(win_cur), .win_below(win_below),
    .nxt_we(nxt_we), .nxt_addr(nxt_addr), .nxt_data(nxt_data),
    .gen_done(gen_done), .gen_count(gen_count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 ph2 = ~ph2;

  int errors = 0;
  int checks = 0;

  // Reference model: both banks, which one is active, generation count.
  logic [7:0] mem_m [2][8];
  int sel_m  = 0;
  int gcnt_m = 0;

  wire [26:0] obs = {win_row, win_above, win_cur, win_below};
  wire [45:0] quiet = {busy, win_valid, gen_done, gen_count, win_row,
                       win_above, win_cur, win_below};

  task automatic cyc();
    @(posedge ph2);
    #1;
  endtask

  function automatic logic [7:0] act(input int r);
    return mem_m[sel_m][r];
  endfunction

  function automatic logic [7:0] exp_above(input int r);
`ifdef GOL_TORUS_EN
    return act((r + 7) % 8);
`else
    return (r == 0) ? 8'h00 : act(r - 1);
`endif
  endfunction

  function automatic logic [7:0] exp_below(input int r);
`ifdef GOL_TORUS_EN
    return act((r + 1) % 8);
`else
    return (r == 7) ? 8'h00 : act(r + 1);
`endif
  endfunction

  function automatic logic [26:0] exp_win(input int r);
    logic [2:0] rr;
    rr = r[2:0];
    return {rr, exp_above(r), act(r), exp_below(r)};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge ph2);
    #1 reset = 1'b0;
    checks++;
    if (quiet !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", quiet);
    end
    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 3'(i); load_data = 8'(i + 1);
      cyc();
      mem_m[0][i] = 8'(i + 1);
    end
    load_en = 1'b0;
    rd_addr = 3'd3;
    #1;
    checks++;
    if (rd_data !== act(3)) begin
      errors++;
      $display("FAIL readback_row3: got %h expected %h", rd_data, act(3));
    end
    #2 reset = 1'b1;
    #2;
    checks++;
    if (quiet !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", quiet);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (quiet !== '0 || rd_data !== act(3)) begin
      errors++;
      $display("FAIL reset_after: got %h/%h expected 0/%h", quiet, rd_data, act(3));
    end
  endtask

  // Full-rate scan with win_ready held, then abort by reset in DRAIN.
  task automatic test_scan_abort();
    bit seen_done;
    win_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (win_valid !== 1'b1 || obs !== exp_win(r)) begin
        errors++;
        $display("FAIL scan_row%0d: got v=%b %h expected v=1 %h", r, win_valid, obs, exp_win(r));
      end
      cyc();
    end
    checks++;
    if (win_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL scan_end: got v=%b busy=%b expected v=0 busy=1", win_valid, busy);
    end
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nxt_we = 1'b1; nxt_addr = 3'(i); nxt_data = 8'($urandom);
      cyc();
    end
    nxt_we = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    sel_m = 0; gcnt_m = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (gen_done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || gen_count !== 16'(gcnt_m)) begin
      errors++;
      $display("FAIL abort_idle: got busy/done activity=%b count=%0d expected 0/%0d", seen_done, gen_count, gcnt_m);
    end
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r);
      #1;
      checks++;
      if (rd_data !== act(r)) begin
        errors++;
        $display("FAIL abort_rd%0d: got %h expected %h", r, rd_data, act(r));
      end
    end
  endtask

  task automatic test_backpressure();
    win_ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (win_valid !== 1'b1 || obs !== exp_win(0)) begin
      errors++;
      $display("FAIL bp_row0: got %h expected %h", obs, exp_win(0));
    end
    win_ready = 1'b1;
    cyc();
    cyc();
    win_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (win_valid !== 1'b1 || obs !== exp_win(2)) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b %h expected v=1 %h", i, win_valid, obs, exp_win(2));
      end
    end
    win_ready = 1'b1;
    for (int r = 3; r < 8; r++) begin
      cyc();
      checks++;
      if (win_valid !== 1'b1 || obs !== exp_win(r)) begin
        errors++;
        $display("FAIL bp_row%0d: got %h expected %h", r, obs, exp_win(r));
      end
    end
    cyc();
    win_ready = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: got v=%b busy=%b expected v=0 busy=1", win_valid, busy);
    end
  endtask

  // Continues the generation left in DRAIN: reverse order, row 4 twice.
  task automatic test_writeback();
    int ord [9];
    int pulses;
    ord = '{7, 6, 5, 4, 4, 3, 2, 1, 0};
    for (int k = 0; k < 9; k++) begin
      nxt_we = 1'b1;
      nxt_addr = 3'(ord[k]);
      nxt_data = (k == 3) ? 8'hFF : 8'(8'hA0 + ord[k]);
      cyc();
      if (k < 8) begin
        checks++;
        if (gen_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL wb_early%0d: got done=%b busy=%b expected 0/1", k, gen_done, busy);
        end
      end
    end
    nxt_we = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (gen_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wb_gen_done: got %0d pulses expected 1", pulses);
    end
    sel_m ^= 1;
    for (int r = 0; r < 8; r++) mem_m[sel_m][r] = 8'(8'hA0 + r);
    gcnt_m++;
    checks++;
    if (gen_count !== 16'(gcnt_m) || busy !== 1'b0) begin
      errors++;
      $display("FAIL wb_count: got %0d busy=%b expected %0d busy=0", gen_count, busy, gcnt_m);
    end
    rd_addr = 3'd4;
    #1;
    checks++;
    if (rd_data !== act(4)) begin
      errors++;
      $display("FAIL wb_rd4: got %h expected %h", rd_data, act(4));
    end
    rd_addr = 3'd0;
    #1;
    checks++;
    if (rd_data !== act(0)) begin
      errors++;
      $display("FAIL wb_rd0: got %h expected %h", rd_data, act(0));
    end
  endtask

  // start+load on one edge, ignored load/start in SCAN, then reset while
  // bank 1 is active.
  task automatic test_same_edge();
    logic [26:0] e;
    e = exp_win(0);
    load_en = 1'b1; load_addr = 3'd0; load_data = 8'h5A; start = 1'b1;
    cyc();
    load_en = 1'b0; start = 1'b0;
    checks++;
    if (win_valid !== 1'b1 || obs !== e) begin
      errors++;
      $display("FAIL same_edge_win: got %h expected %h", obs, e);
    end
    mem_m[sel_m][0] = 8'h5A;
    rd_addr = 3'd0;
    #1;
    checks++;
    if (rd_data !== act(0)) begin
      errors++;
      $display("FAIL same_edge_rd: got %h expected %h", rd_data, act(0));
    end
    win_ready = 1'b1;
    cyc();
    cyc();
    win_ready = 1'b0;
    load_en = 1'b1; load_addr = 3'd1; load_data = ~act(1); start = 1'b1;
    cyc();
    load_en = 1'b0; start = 1'b0;
    rd_addr = 3'd1;
    #1;
    checks++;
    if (obs !== exp_win(2) || rd_data !== act(1)) begin
      errors++;
      $display("FAIL ignored_in_scan: got %h/%h expected %h/%h", obs, rd_data, exp_win(2), act(1));
    end
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    sel_m = 0; gcnt_m = 0;
    cyc();
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r);
      #1;
      checks++;
      if (rd_data !== act(r) || busy !== 1'b0 || gen_count !== 16'(gcnt_m)) begin
        errors++;
        $display("FAIL reset_bank1_rd%0d: got %h busy=%b cnt=%0d expected %h 0 %0d", r, rd_data, busy, gen_count, act(r), gcnt_m);
      end
    end
  endtask

  // Random backpressure, random write order with interleaved junk rewrites.
  task automatic test_random_gens(input int n);
    int ord [8];
    logic [7:0] nd [8];
    int wi, er, budget, pulses, j, tmp;
    bit ev, wr, junk, rdy;
    for (int g = 0; g < n; g++) begin
      for (int i = 0; i < 8; i++) begin
        ord[i] = i;
        nd[i] = 8'($urandom);
      end
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      ev = 1'b1; er = 0; wi = 0; budget = 0;
      while ((ev || wi < 8) && budget < 300) begin
        budget++;
        checks++;
        if (win_valid !== ev || busy !== 1'b1 || (ev && obs !== exp_win(er))) begin
          errors++;
          $display("FAIL rnd_g%0d_win: got v=%b busy=%b %h expected v=%b %h", g, win_valid, busy, obs, ev, exp_win(er));
        end
        rd_addr = 3'($urandom_range(7, 0));
        #1;
        checks++;
        if (rd_data !== act(int'(rd_addr))) begin
          errors++;
          $display("FAIL rnd_g%0d_rd: got %h expected %h", g, rd_data, act(int'(rd_addr)));
        end
        rdy = 1'($urandom_range(1, 0));
        win_ready = rdy;
        wr = (wi < 8) && ($urandom_range(1, 0) == 1);
        junk = wr && (wi < 7) && ($urandom_range(3, 0) == 0);
        nxt_we = wr;
        if (wr) begin
          nxt_addr = 3'(ord[wi]);
          nxt_data = junk ? ~nd[ord[wi]] : nd[ord[wi]];
        end
        cyc();
        if (ev && rdy) begin
          if (er == 7) ev = 1'b0;
          else er++;
        end
        if (wr && !junk) wi++;
      end
      nxt_we = 1'b0;
      win_ready = 1'b0;
      if (budget >= 300) begin
        checks++;
        errors++;
        $display("FAIL rnd_g%0d_timeout: got no completion expected scan and write-back done", g);
      end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        cyc();
        if (gen_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
        errors++;
        $display("FAIL rnd_g%0d_done: got %0d pulses expected 1", g, pulses);
      end
      sel_m ^= 1;
      for (int r = 0; r < 8; r++) mem_m[sel_m][r] = nd[r];
      gcnt_m++;
      checks++;
      if (gen_count !== 16'(gcnt_m) || busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd_g%0d_count: got %0d busy=%b expected %0d busy=0", g, gen_count, busy, gcnt_m);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan_abort();
    test_backpressure();
    test_writeback();
    test_same_edge();
    test_random_gens(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
